// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared definitions for the 7-segment scan controller:
//     - state_t    : scan FSM states (ST_BLANK, ST_SHOW)
//     - SEG_BLANK  : all-segments-off pattern
//     - SEG_TABLE  : 16-entry nibble -> segment table, gfedcba order,
//                    active-high; codes 10..15 are invalid BCD and blank.
//     - seg_decode : table lookup helper
package seg7_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
        SEG_BLANK, SEG_BLANK, SEG_BLANK,
        SEG_BLANK, SEG_BLANK, SEG_BLANK
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/bcd_seg7_lut.sv
// bcd_seg7_lut
//   Combinational BCD-to-7-segment decoder built on the package table.
//   Ports:
//     nib  in  4  BCD nibble
//     seg  out 7  segment pattern, gfedcba order, active-high;
//                 invalid codes (10..15) give all segments off.
module bcd_seg7_lut
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg_decode(nib);
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Time-multiplexed scan controller for a multi-digit 7-segment bank.
//   A packed BCD word is captured into a shadow register via a load/ready
//   handshake; digits are lit one at a time for DWELL_CYC cycles with a
//   BLANK_CYC all-off gap between them. seg/dig_en are registered and
//   follow the FSM state by one cycle.
//   Ports:
//     clk     in   1             rising-edge clock
//     rst     in   1             synchronous reset, active-high
//     load    in   1             capture request for bcd_in
//     bcd_in  in   4*NUM_DIGITS  packed BCD, digit 0 in bits [3:0]
//     ready   out  1             load is accepted this cycle when high
//     seg     out  7             segment drive, gfedcba order, active-high
//     dig_en  out  NUM_DIGITS    one-hot digit enable, zero while blanking
//   Configuration macro:
//     LZ_BLANK_EN  when defined, leading zeros are suppressed (digit 0
//                  always shows); otherwise every digit is decoded.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DWELL_CYC  = 50000,
    parameter int unsigned BLANK_CYC  = 500,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic                    ready,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_en
);

    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        timer_q, timer_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [3:0]              disp_nib_q, disp_nib_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;

    logic                    blank_done;
    logic                    show_done;
    logic [3:0]              cur_nib;
    logic [6:0]              lut_seg;

`ifdef LZ_BLANK_EN
    logic                    lz_q, lz_d;
    logic                    upper_zero;
`endif

    bcd_seg7_lut u_lut (
        .nib (disp_nib_q),
        .seg (lut_seg)
    );

    always_comb begin
        blank_done = (state_q == ST_BLANK) && (timer_q == CNT_W'(BLANK_CYC - 1));
        show_done  = (state_q == ST_SHOW)  && (timer_q == CNT_W'(DWELL_CYC - 1));
    end

    // Nibble of the digit about to be shown (and, for leading-zero
    // suppression, whether it and everything above it is zero).
    always_comb begin
        cur_nib = 4'h0;
`ifdef LZ_BLANK_EN
        upper_zero = 1'b0;
`endif
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib = shadow_q[4*i +: 4];
`ifdef LZ_BLANK_EN
                upper_zero = (i != 0) && ((shadow_q >> (4*i)) == '0);
`endif
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + 1'b1;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        disp_nib_d = disp_nib_q;
`ifdef LZ_BLANK_EN
        lz_d       = lz_q;
`endif

        // The SHOW-entry cycle is the only one where a load is refused.
        ready = ~blank_done;
        if (load && ready) begin
            shadow_d = bcd_in;
        end

        case (state_q)
            ST_BLANK: begin
                if (blank_done) begin
                    state_d    = ST_SHOW;
                    timer_d    = '0;
                    disp_nib_d = cur_nib;
`ifdef LZ_BLANK_EN
                    lz_d       = upper_zero;
`endif
                end
            end
            ST_SHOW: begin
                if (show_done) begin
                    state_d = ST_BLANK;
                    timer_d = '0;
                    idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_BLANK;
                timer_d = '0;
            end
        endcase

        // Output registers follow the current state one cycle later.
        dig_en_d = '0;
        seg_d    = SEG_BLANK;
        if (state_q == ST_SHOW) begin
            dig_en_d = NUM_DIGITS'(1) << idx_q;
`ifdef LZ_BLANK_EN
            seg_d    = lz_q ? SEG_BLANK : lut_seg;
`else
            seg_d    = lut_seg;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BLANK;
            timer_q    <= '0;
            idx_q      <= '0;
            shadow_q   <= '0;
            disp_nib_q <= '0;
            seg_q      <= SEG_BLANK;
            dig_en_q   <= '0;
`ifdef LZ_BLANK_EN
            lz_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            disp_nib_q <= disp_nib_d;
            seg_q      <= seg_d;
            dig_en_q   <= dig_en_d;
`ifdef LZ_BLANK_EN
            lz_q       <= lz_d;
`endif
        end
    end

    assign seg    = seg_q;
    assign dig_en = dig_en_q;

endmodule
